// File: rtl/arcsin_seq.sv
// rtl/arcsin_seq.sv - sequential coarse/fine arcsin over the sine-hundredths table
// Optional nearest-angle rounding when ARCSIN_NEAREST_EN is defined.
module arcsin_seq #(
    parameter int unsigned COARSE_STEP = 10
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic       sign_i,
    input  logic       whole_i,
    input  logic [6:0] fraction_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       angle_sign_o,
    output logic [6:0] angle_o
);
    typedef enum logic [1:0] {S_IDLE, S_COARSE, S_FINE, S_DONE} state_t;

    localparam logic [7:0] STEP = 8'(COARSE_STEP);

    state_t     state_q, state_d;
    logic [6:0] k_q, k_d, tgt_q, tgt_d, angle_q, angle_d;
    logic       sign_q, sign_d, err_pend_q, err_pend_d;
    logic       busy_q, busy_d, done_q, done_d, err_q, err_d, asign_q, asign_d;
    logic [6:0] t_k;
    logic [7:0] k_step, k_inc, f0_diff;

    function automatic logic [6:0] sin_tbl(input logic [6:0] k);
        logic [6:0] t;
        case (k)
            7'd0: t = 7'd0;   7'd1: t = 7'd1;   7'd2: t = 7'd3;   7'd3: t = 7'd5;
            7'd4: t = 7'd6;   7'd5: t = 7'd8;   7'd6: t = 7'd10;  7'd7: t = 7'd12;
            7'd8: t = 7'd13;  7'd9: t = 7'd15;  7'd10: t = 7'd17; 7'd11: t = 7'd19;
            7'd12: t = 7'd20; 7'd13: t = 7'd22; 7'd14: t = 7'd24; 7'd15: t = 7'd25;
            7'd16: t = 7'd27; 7'd17: t = 7'd29; 7'd18: t = 7'd30; 7'd19: t = 7'd32;
            7'd20: t = 7'd34; 7'd21: t = 7'd35; 7'd22: t = 7'd37; 7'd23: t = 7'd39;
            7'd24: t = 7'd40; 7'd25: t = 7'd42; 7'd26: t = 7'd43; 7'd27: t = 7'd45;
            7'd28: t = 7'd46; 7'd29: t = 7'd48; 7'd30: t = 7'd50; 7'd31: t = 7'd51;
            7'd32: t = 7'd52; 7'd33: t = 7'd54; 7'd34: t = 7'd55; 7'd35: t = 7'd57;
            7'd36: t = 7'd58; 7'd37: t = 7'd60; 7'd38: t = 7'd61; 7'd39: t = 7'd62;
            7'd40: t = 7'd64; 7'd41: t = 7'd65; 7'd42: t = 7'd66; 7'd43: t = 7'd68;
            7'd44: t = 7'd69; 7'd45: t = 7'd70; 7'd46: t = 7'd71; 7'd47: t = 7'd73;
            7'd48: t = 7'd74; 7'd49: t = 7'd75; 7'd50: t = 7'd76; 7'd51: t = 7'd77;
            7'd52: t = 7'd78; 7'd53: t = 7'd79; 7'd54: t = 7'd80; 7'd55: t = 7'd81;
            7'd56: t = 7'd82; 7'd57: t = 7'd83; 7'd58: t = 7'd84; 7'd59: t = 7'd85;
            7'd60: t = 7'd86; 7'd61: t = 7'd87; 7'd62: t = 7'd88;
            7'd63, 7'd64: t = 7'd89;
            7'd65: t = 7'd90; 7'd66: t = 7'd91;
            7'd67, 7'd68: t = 7'd92;
            7'd69, 7'd70: t = 7'd93;
            7'd71: t = 7'd94;
            7'd72, 7'd73: t = 7'd95;
            7'd74, 7'd75: t = 7'd96;
            7'd76, 7'd77, 7'd78: t = 7'd97;
            7'd79, 7'd80, 7'd81: t = 7'd98;
            7'd82, 7'd83, 7'd84, 7'd85, 7'd86, 7'd87, 7'd88, 7'd89: t = 7'd99;
            default: t = 7'd100;
        endcase
        return t;
    endfunction

`ifdef ARCSIN_NEAREST_EN
    logic [6:0] t_km1;
    assign t_km1 = sin_tbl(k_q - 7'd1);
`endif

    assign t_k     = sin_tbl(k_q);
    assign k_step  = {1'b0, k_q} + STEP;
    assign k_inc   = {1'b0, k_q} + 8'd1;
    assign f0_diff = k_inc - STEP;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        tgt_d      = tgt_q;
        sign_d     = sign_q;
        err_pend_d = err_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        asign_d    = asign_q;
        angle_d    = angle_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    tgt_d  = whole_i ? 7'd100 : fraction_i;
                    sign_d = sign_i;
                    k_d    = 7'd0;
                    if (fraction_i > 7'd99 || (whole_i && fraction_i != 7'd0)) begin
                        err_pend_d = 1'b1;
                        sign_d     = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        err_pend_d = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = S_COARSE;
                    end
                end
            end
            S_COARSE: begin
                if (t_k >= tgt_q) begin
                    k_d     = (k_inc > STEP) ? f0_diff[6:0] : 7'd0;
                    state_d = S_FINE;
                end else if (k_step > 8'd90) begin
                    k_d     = k_inc[6:0];
                    state_d = S_FINE;
                end else begin
                    k_d = k_step[6:0];
                end
            end
            S_FINE: begin
                if (t_k >= tgt_q) begin
                    state_d = S_DONE;
`ifdef ARCSIN_NEAREST_EN
                    // ties between neighbours resolve to the lower angle
                    if (k_q != 7'd0 && t_k != tgt_q && (tgt_q - t_km1) <= (t_k - tgt_q))
                        k_d = k_q - 7'd1;
`endif
                end else begin
                    k_d = k_inc[6:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = err_pend_q;
                angle_d = k_q;
                asign_d = sign_q && (k_q != 7'd0);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            k_q        <= 7'd0;
            tgt_q      <= 7'd0;
            sign_q     <= 1'b0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            asign_q    <= 1'b0;
            angle_q    <= 7'd0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            tgt_q      <= tgt_d;
            sign_q     <= sign_d;
            err_pend_q <= err_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            asign_q    <= asign_d;
            angle_q    <= angle_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign angle_sign_o = asign_q;
    assign angle_o      = angle_q;
endmodule

// File: tb/tb_arcsin_seq.sv
// tb/tb_arcsin_seq.sv - scoreboard bench for arcsin_seq with a trig-based reference model
module tb_arcsin_seq;
    localparam int S = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sgn = 1'b0;
    logic       whole = 1'b0;
    logic [6:0] frac = 7'd0;
    logic       busy, done, err, asg;
    logic [6:0] ang;

    arcsin_seq #(.COARSE_STEP(S)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .sign_i(sgn),
        .whole_i(whole), .fraction_i(frac), .busy_o(busy), .done_o(done),
        .err_o(err), .angle_sign_o(asg), .angle_o(ang)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int err;
        int sg;
        int ang;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   T[0:90];

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: table from real sine (truncated hundredths), latency from arithmetic on stride multiples.
    function automatic exp_t model(input int s, input int w, input int f);
        exp_t e;
        int   tgt, ce, km, c, f0;
        e.acc = 0;
        if (f > 99 || (w != 0 && f != 0)) begin
            e.err = 1; e.sg = 0; e.ang = 0; e.lat = 1;
            return e;
        end
        tgt = (w != 0) ? 100 : f;
        ce = 0;
        while (T[ce] < tgt) ce++;
        km = ((ce + S - 1) / S) * S;
        if (km > 90) begin
            km = (90 / S) * S;
            c  = km / S + 1;
            f0 = km + 1;
        end else begin
            c  = km / S + 1;
            f0 = (km - S + 1 > 0) ? km - S + 1 : 0;
        end
        e.lat = c + (ce - f0 + 1) + 1;
        e.ang = ce;
`ifdef ARCSIN_NEAREST_EN
        if (ce > 0 && T[ce] != tgt && (tgt - T[ce-1]) <= (T[ce] - tgt)) e.ang = ce - 1;
`endif
        e.err = 0;
        e.sg  = (s != 0 && e.ang != 0) ? 1 : 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("err", int'(err), e.err);
                chk("angle_sign", int'(asg), e.sg);
                chk("angle", int'(ang), e.ang);
                chk("latency", cyc - e.acc, e.lat);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic start_op(input int s, input int w, input int f, input exp_t e, input bit push);
        @(negedge clk);
        sgn = s[0]; whole = w[0]; frac = f[6:0]; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.acc = cyc;
        if (push) sb.push_back(e);
        chk("busy_after_accept", int'(busy), (e.err != 0) ? 0 : 1);
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (n_done == d0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (n_done == d0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input int s, input int w, input int f, input exp_t e);
        int d0 = n_done;
        start_op(s, w, f, e, 1'b1);
        wait_done(d0);
    endtask

    function automatic exp_t mk(input int er, input int sg, input int an, input int lat);
        exp_t e;
        e.err = er; e.sg = sg; e.ang = an; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d0, s, w, f;
        exp_t e;
        for (int k = 0; k <= 90; k++)
            T[k] = int'($floor(100.0 * $sin(k * 3.14159265358979 / 180.0) + 1.0e-6));

        #2;
        chk("reset_outputs", int'({busy, done, err, asg, ang}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-derived expectations
        run(0, 0, 0,   mk(0, 0, 0, 3));
        run(1, 0, 50,  mk(0, 1, 30, 15));
        run(0, 1, 0,   mk(0, 0, 90, 21));
        run(0, 0, 99,  mk(0, 0, 82, 13));
`ifdef ARCSIN_NEAREST_EN
        run(0, 0, 4,   mk(0, 0, 2, 6));
`else
        run(0, 0, 4,   mk(0, 0, 3, 6));
`endif
        run(1, 0, 89,  mk(0, 1, 63, 12));
        run(1, 0, 120, mk(1, 0, 0, 1));
        run(0, 1, 5,   mk(1, 0, 0, 1));
        run(1, 0, 0,   mk(0, 0, 0, 3));

        // A second start while busy must be ignored
        d0 = n_done;
        start_op(1, 0, 50, mk(0, 1, 30, 15), 1'b1);
        repeat (3) @(negedge clk);
        sgn = 1'b0; frac = 7'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0);
        repeat (5) @(negedge clk);

        // Reset in the middle of a search: outputs clear, no done follows
        start_op(0, 1, 0, mk(0, 0, 90, 21), 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", int'({busy, done, err, asg, ang}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midreset_busy", int'(busy), 0);

        for (int i = 0; i < 150; i++) begin
            s = int'($urandom_range(0, 1));
            w = ($urandom_range(0, 7) == 0) ? 1 : 0;
            f = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 99));
            if (w != 0 && $urandom_range(0, 1) == 0) f = 0;
            e = model(s, w, f);
            run(s, w, f, e);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
